fetch_pc_unit: RTL

- PC register and instruction-fetch sequencer for the sequential core; feeds decode and consumes the take_branch / branch_target redirect from the branch unit.
- Issues one instruction-memory request at a time over a valid/ready handshake and holds the returned word until decode accepts it.
- Advances to PC+4 or to the redirect target, discards responses made stale by a redirect, and flags misaligned targets.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_pc_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch PC unit: state encoding and
// fetch constants.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_ERROR = 3'd4
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_pc_unit.sv
// PC register and single-outstanding instruction-fetch sequencer: issues one
// imem request at a time, holds the word for decode, handles redirects.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            misaligned,
  output logic [XLEN-1:0] fault_addr
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic            target_misaligned;
  logic [XLEN-1:0] pc_plus4;

  assign target_misaligned = (redirect_target[1:0] != 2'b00);
  assign pc_plus4          = pc + XLEN'(INSTR_BYTES);

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      instr_data <= '0;
      instr_pc   <= '0;
      misaligned <= 1'b0;
      fault_addr <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (redirect_valid && target_misaligned) begin
            state      <= S_ERROR;
            misaligned <= 1'b1;
            fault_addr <= redirect_target;
          end else begin
            if (redirect_valid) pc <= redirect_target;
            // An accepted request for the old PC must have its response dropped.
            if (imem_req_ready) begin
              state <= S_WAIT;
              kill  <= redirect_valid;
            end
          end
        end

        S_WAIT: begin
          if (redirect_valid && target_misaligned) begin
            state      <= S_ERROR;
            misaligned <= 1'b1;
            fault_addr <= redirect_target;
          end else if (imem_resp_valid) begin
            if (kill || redirect_valid) begin
              kill  <= 1'b0;
              state <= S_REQ;
              if (redirect_valid) pc <= redirect_target;
            end else begin
              instr_data <= imem_resp_data;
              instr_pc   <= pc;
              state      <= S_HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_target;
            kill <= 1'b1;
          end
        end

        S_HOLD: begin
          if (redirect_valid && target_misaligned) begin
            state      <= S_ERROR;
            misaligned <= 1'b1;
            fault_addr <= redirect_target;
          end else if (instr_ready) begin
            pc    <= redirect_valid ? redirect_target : pc_plus4;
            state <= S_REQ;
          end else if (redirect_valid) begin
            pc    <= redirect_target;
            state <= S_REQ;
          end
        end

        S_ERROR: state <= S_ERROR;

        default: state <= S_ERROR;
      endcase
    end
  end

endmodule : fetch_pc_unit
